// File: rtl/masked_sbox_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes128_package
// Brief  : Shared types, constants and GF(2^8) helpers for the masked S-box slice.
// Rev    : 1.0  initial release
// ============================================================================
package aes128_package;

  typedef logic [7:0] bv8_t;

  typedef enum logic [1:0] {
    HPC1 = 2'd0,
    HPC2 = 2'd1
  } stage_type_t;

  typedef enum logic {
    SRC_KEY = 1'b0,
    SRC_ST  = 1'b1
  } sbox_src_t;

  typedef struct packed {
    logic      valid;
    sbox_src_t src;
    logic [3:0] idx;
  } sbox_tag_t;

  localparam int c_sbox_latency = 3;

  // Fresh bits consumed per S-box evaluation; scales with the number of share pairs.
  function automatic int num_inv_random(input int shares, input stage_type_t stage);
    int pairs;
    pairs = shares * (shares - 1) / 2;
    return (stage == HPC1) ? 32 * pairs : 24 * pairs;
  endfunction

  function automatic bv8_t gf_mul(input bv8_t a, input bv8_t b);
    bv8_t p;
    bv8_t x;
    bv8_t y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic bv8_t sbox_fwd(input bv8_t x);
    bv8_t sq;
    bv8_t inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/masked_aes_sbox_fwd.sv
`default_nettype none
// ============================================================================
// Module : masked_aes_sbox_fwd
// Brief  : Pipelined shared AES forward S-box; output re-shared with fresh masks.
// Rev    : 1.0  initial release
// ============================================================================
module masked_aes_sbox_fwd
  import aes128_package::*;
#(
  parameter int          NUM_SHARES = 2,
  parameter stage_type_t STAGE_TYPE = HPC1,
  parameter int          LATENCY    = c_sbox_latency,
  localparam int         NUM_RANDOM = num_inv_random(NUM_SHARES, STAGE_TYPE)
) (
  input  logic                        in_clock,
  input  logic                        in_reset,
  input  bv8_t [NUM_SHARES-1:0]       in_shares,
  input  logic [NUM_RANDOM-1:0]       in_random,
  output bv8_t [NUM_SHARES-1:0]       out_shares
);

  localparam int c_chunks = NUM_RANDOM / 8;

  bv8_t                  w_plain;
  bv8_t                  w_sub;
  bv8_t [NUM_SHARES-1:0] w_masked;
  bv8_t [NUM_SHARES-1:0] r_pipe [LATENCY];

  // Shares 1..N-1 take fresh masks; surplus random chunks fold into share 1.
  always_comb begin
    w_plain = '0;
    for (int i = 0; i < NUM_SHARES; i++) w_plain = w_plain ^ in_shares[i];
    w_sub    = sbox_fwd(w_plain);
    w_masked = '0;
    for (int i = 1; i < NUM_SHARES; i++) w_masked[i] = in_random[8*(i-1) +: 8];
    for (int j = NUM_SHARES - 1; j < c_chunks; j++) w_masked[1] = w_masked[1] ^ in_random[8*j +: 8];
    w_masked[0] = w_sub;
    for (int i = 1; i < NUM_SHARES; i++) w_masked[0] = w_masked[0] ^ w_masked[i];
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      for (int s = 0; s < LATENCY; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= w_masked;
      for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign out_shares = r_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/masked_sbox_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module : masked_sbox_tag_pipe
// Brief  : Shift register of S-box ownership tags, depth matched to the S-box.
// Rev    : 1.0  initial release
// ============================================================================
module masked_sbox_tag_pipe
  import aes128_package::*;
#(
  parameter int DEPTH = c_sbox_latency
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  sbox_tag_t        in_tag,
  output sbox_tag_t        out_tag,
  output logic [DEPTH-1:0] out_valids
);

  sbox_tag_t r_stage [DEPTH];

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= in_tag;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  always_comb begin
    out_valids = '0;
    for (int s = 0; s < DEPTH; s++) out_valids[s] = r_stage[s].valid;
  end

  assign out_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/masked_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module : masked_sbox_arbiter
// Brief  : Round-robin sharing of one masked S-box between key schedule and
//          SubBytes. Option MASKED_SBOX_ARB_ZEROIZE_EN zeroes idle byte outputs.
// Rev    : 1.0  initial release
// ============================================================================
module masked_sbox_arbiter
  import aes128_package::*;
#(
  parameter int          NUM_SHARES   = 2,
  parameter stage_type_t STAGE_TYPE   = HPC1,
  parameter int          SBOX_LATENCY = c_sbox_latency,
  localparam int         NUM_RANDOM   = num_inv_random(NUM_SHARES, STAGE_TYPE)
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_key_valid,
  input  bv8_t [NUM_SHARES-1:0] in_key_byte,
  input  logic [1:0]            in_key_idx,
  output logic                  out_key_ready,
  input  logic                  in_st_valid,
  input  bv8_t [NUM_SHARES-1:0] in_st_byte,
  input  logic [3:0]            in_st_idx,
  output logic                  out_st_ready,
  input  logic [NUM_RANDOM-1:0] in_random,
  input  logic                  in_random_valid,
  output logic                  out_key_valid,
  output bv8_t [NUM_SHARES-1:0] out_key_byte,
  output logic [1:0]            out_key_idx,
  output logic                  out_st_valid,
  output bv8_t [NUM_SHARES-1:0] out_st_byte,
  output logic [3:0]            out_st_idx,
  output logic                  out_busy,
  output logic                  out_rand_err
);

  logic                    w_issue;
  logic                    w_grant_key;
  logic                    w_grant_st;
  logic                    r_last_key;
  logic                    r_rand_err;
  bv8_t [NUM_SHARES-1:0]   w_sbox_in;
  bv8_t [NUM_SHARES-1:0]   w_sbox_out;
  sbox_tag_t               w_tag_in;
  sbox_tag_t               w_tag_out;
  logic [SBOX_LATENCY-1:0] w_tag_valids;

  // Key wins unless state also requests and key took the previous slot.
  assign w_issue     = !in_reset && in_random_valid && (in_key_valid || in_st_valid);
  assign w_grant_key = w_issue && in_key_valid && (!in_st_valid || !r_last_key);
  assign w_grant_st  = w_issue && !w_grant_key;

  assign out_key_ready = w_grant_key;
  assign out_st_ready  = w_grant_st;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_last_key <= 1'b0;
    end else if (w_issue) begin
      r_last_key <= w_grant_key;
    end
  end

  // Idle cycles feed all-zero shares so no stale secret reaches the gadget.
  always_comb begin
    w_sbox_in = '0;
    if (w_grant_key) w_sbox_in = in_key_byte;
    else if (w_grant_st) w_sbox_in = in_st_byte;
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue;
    w_tag_in.src   = w_grant_st ? SRC_ST : SRC_KEY;
    w_tag_in.idx   = w_grant_key ? {2'b00, in_key_idx} : (w_grant_st ? in_st_idx : 4'h0);
  end

  masked_aes_sbox_fwd #(
    .NUM_SHARES (NUM_SHARES),
    .STAGE_TYPE (STAGE_TYPE),
    .LATENCY    (SBOX_LATENCY)
  ) u_sbox (
    .in_clock   (in_clock),
    .in_reset   (in_reset),
    .in_shares  (w_sbox_in),
    .in_random  (in_random),
    .out_shares (w_sbox_out)
  );

  masked_sbox_tag_pipe #(
    .DEPTH      (SBOX_LATENCY)
  ) u_tag_pipe (
    .in_clock   (in_clock),
    .in_reset   (in_reset),
    .in_tag     (w_tag_in),
    .out_tag    (w_tag_out),
    .out_valids (w_tag_valids)
  );

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_rand_err <= 1'b0;
    end else if (!in_random_valid && (|w_tag_valids)) begin
      r_rand_err <= 1'b1;
    end
  end

  assign out_rand_err  = r_rand_err;
  assign out_busy      = (|w_tag_valids) || w_issue;
  assign out_key_valid = w_tag_out.valid && (w_tag_out.src == SRC_KEY);
  assign out_st_valid  = w_tag_out.valid && (w_tag_out.src == SRC_ST);
  assign out_key_idx   = w_tag_out.idx[1:0];
  assign out_st_idx    = w_tag_out.idx;

`ifdef MASKED_SBOX_ARB_ZEROIZE_EN
  assign out_key_byte = out_key_valid ? w_sbox_out : '0;
  assign out_st_byte  = out_st_valid  ? w_sbox_out : '0;
`else
  assign out_key_byte = w_sbox_out;
  assign out_st_byte  = w_sbox_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_masked_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_masked_sbox_arbiter
// Brief  : Scoreboard bench for masked_sbox_arbiter (2 shares, latency 3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_masked_sbox_arbiter;
  import aes128_package::*;

  localparam int c_nr  = num_inv_random(2, HPC1);
  localparam int c_lat = 3;

  typedef struct {
    logic       src;
    logic [3:0] idx;
    logic [7:0] val;
    int         due;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  key_valid = 1'b0;
  logic [1:0][7:0]       key_byte = '0;
  logic [1:0]            key_idx = '0;
  logic                  key_ready;
  logic                  st_valid = 1'b0;
  logic [1:0][7:0]       st_byte = '0;
  logic [3:0]            st_idx = '0;
  logic                  st_ready;
  logic [c_nr-1:0]       random = '0;
  logic                  random_valid = 1'b0;
  logic                  okey_valid;
  logic [1:0][7:0]       okey_byte;
  logic [1:0]            okey_idx;
  logic                  ost_valid;
  logic [1:0][7:0]       ost_byte;
  logic [3:0]            ost_idx;
  logic                  busy;
  logic                  rand_err;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  masked_sbox_arbiter #(
    .NUM_SHARES   (2),
    .STAGE_TYPE   (HPC1),
    .SBOX_LATENCY (c_lat)
  ) dut (
    .in_clock        (clk),
    .in_reset        (rst),
    .in_key_valid    (key_valid),
    .in_key_byte     (key_byte),
    .in_key_idx      (key_idx),
    .out_key_ready   (key_ready),
    .in_st_valid     (st_valid),
    .in_st_byte      (st_byte),
    .in_st_idx       (st_idx),
    .out_st_ready    (st_ready),
    .in_random       (random),
    .in_random_valid (random_valid),
    .out_key_valid   (okey_valid),
    .out_key_byte    (okey_byte),
    .out_key_idx     (okey_idx),
    .out_st_valid    (ost_valid),
    .out_st_byte     (ost_byte),
    .out_st_idx      (ost_idx),
    .out_busy        (busy),
    .out_rand_err    (rand_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) random = c_nr'($urandom);

  // Result monitor: every emerging result must match the oldest expectation.
  always @(negedge clk) begin
    logic       g_src;
    logic [3:0] g_idx;
    logic [7:0] g_val;
    if (okey_valid || ost_valid) begin
      n_checks++;
      g_src = ost_valid;
      g_idx = ost_valid ? ost_idx : {2'b00, okey_idx};
      g_val = ost_valid ? (ost_byte[0] ^ ost_byte[1]) : (okey_byte[0] ^ okey_byte[1]);
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result cyc=%0d src=%0d idx=%0d val=%h, required none", cyc, g_src, g_idx, g_val);
      end else begin
        mon_e = sb.pop_front();
        if ((okey_valid && ost_valid) || g_src !== mon_e.src || g_idx !== mon_e.idx ||
            g_val !== mon_e.val || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL result cyc=%0d src=%0d idx=%0d val=%h both=%0d, required cyc=%0d src=%0d idx=%0d val=%h",
                   cyc, g_src, g_idx, g_val, okey_valid && ost_valid, mon_e.due, mon_e.src, mon_e.idx, mon_e.val);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_result cyc=%0d, required src=%0d idx=%0d val=%h at cyc=%0d",
               cyc, sb[0].src, sb[0].idx, sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end
`ifdef MASKED_SBOX_ARB_ZEROIZE_EN
    n_checks++;
    if ((!okey_valid && okey_byte !== '0) || (!ost_valid && ost_byte !== '0)) begin
      n_fail++;
      $display("FAIL zeroize cyc=%0d key=%h st=%h, required 0 when invalid", cyc, okey_byte, ost_byte);
    end
`endif
  end

  task automatic idle();
    key_valid = 1'b0;
    st_valid  = 1'b0;
  endtask

  task automatic set_key(input logic [7:0] v, input logic [1:0] idx);
    logic [7:0] m;
    m = 8'($urandom);
    key_valid = 1'b1;
    key_byte  = {m, v ^ m};
    key_idx   = idx;
  endtask

  task automatic set_st(input logic [7:0] v, input logic [3:0] idx);
    logic [7:0] m;
    m = 8'($urandom);
    st_valid = 1'b1;
    st_byte  = {m, v ^ m};
    st_idx   = idx;
  endtask

  task automatic push(input logic src, input logic [3:0] idx, input logic [7:0] val);
    exp_t e;
    e.src = src;
    e.idx = idx;
    e.val = val;
    e.due = cyc + c_lat;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key_valid    = 1'b1;
    random_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({okey_valid, ost_valid, key_ready, st_ready, busy, rand_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b, required 000000",
               {okey_valid, ost_valid, key_ready, st_ready, busy, rand_err});
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

  task automatic test_single_key();
    @(negedge clk);
    key_valid    = 1'b1;
    key_byte     = {8'h5a, 8'h5a};
    key_idx      = 2'd2;
    random_valid = 1'b1;
    #1;
    n_checks++;
    if ({key_ready, st_ready, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_key_ready got=%b, required 101", {key_ready, st_ready, busy});
    end
    push(SRC_KEY, 4'd2, 8'h63);
    @(negedge clk);
    idle();
    drain();
  endtask

  task automatic test_alternate();
    logic exp_k [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int ks;
    int ss;
    ks = 0;
    ss = 0;
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      if (ks < 2) set_key(8'h01, 2'(ks));
      if (ss < 2) set_st(8'h53, 4'(ss));
      random_valid = 1'b1;
      #1;
      n_checks++;
      if ({key_ready, st_ready} !== {exp_k[c], !exp_k[c]}) begin
        n_fail++;
        $display("FAIL alternate_grant c=%0d got=%b, required %b", c, {key_ready, st_ready}, {exp_k[c], !exp_k[c]});
      end
      if (exp_k[c]) begin
        push(SRC_KEY, 4'(ks), 8'h7c);
        ks++;
      end else begin
        push(SRC_ST, 4'(ss), 8'hed);
        ss++;
      end
    end
    @(negedge clk);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                             8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      set_st(8'(i), 4'(i));
      random_valid = 1'b1;
      #1;
      n_checks++;
      if ({key_ready, st_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL stream_ready i=%0d got=%b, required 01", i, {key_ready, st_ready});
      end
      push(SRC_ST, 4'(i), tbl[i]);
    end
    @(negedge clk);
    idle();
    drain();
  endtask

  task automatic test_rand_protocol();
    @(negedge clk);
    set_key(8'h00, 2'd1);
    random_valid = 1'b0;
    #1;
    n_checks++;
    if ({key_ready, st_ready, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_random_ready got=%b, required 000", {key_ready, st_ready, busy});
    end
    @(negedge clk);
    n_checks++;
    if (rand_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_err_idle got=%b, required 0", rand_err);
    end
    random_valid = 1'b1;
    #1;
    n_checks++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_issue_ready got=%b, required 1", key_ready);
    end
    push(SRC_KEY, 4'd1, 8'h63);
    @(negedge clk);
    idle();
    random_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rand_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_err_set got=%b, required 1", rand_err);
    end
    @(negedge clk);
    random_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (rand_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_err_sticky got=%b, required 1", rand_err);
    end
    drain();
  endtask

  task automatic test_inflight_reset();
    int seen;
    seen = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      idle();
      set_st(8'(i), 4'(i));
      random_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({okey_valid, ost_valid, key_ready, st_ready, busy, rand_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL inflight_reset got=%b, required 000000",
               {okey_valid, ost_valid, key_ready, st_ready, busy, rand_err});
    end
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (okey_valid || ost_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL dropped_results got=%0d results, required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_key();
    test_alternate();
    test_back_to_back();
    test_rand_protocol();
    test_inflight_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
